// File: rtl/oqpsk_chip_tx.sv
// O-QPSK transmit chip serialiser: accepts 32-chip words and emits one chip every Tc clocks,
// with even chips on the I rail and odd chips on the Q rail, so Q lags I by one chip period.
module oqpsk_chip_tx #(
    parameter int CHIPS = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_nb_P,
    input  logic             i_valid,
    input  logic [CHIPS-1:0] i_chips,
    output logic             o_ready,
    output logic             o_i,
    output logic             o_q,
    output logic             o_chip_stb,
    output logic             o_sym_done,
    output logic             o_busy
);

    localparam int               IDX_W    = $clog2(CHIPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHIPS - 1);
    localparam logic [CNT_W-1:0] TC_MIN   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_nx;
    logic [CHIPS-1:0] shadow, shadow_nx;
    logic             full, full_nx;
    logic [CHIPS-1:0] active, active_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [IDX_W-1:0] idx_inc;
    logic [CNT_W-1:0] tc_lat, tc_nx;
    logic [CNT_W-1:0] tc_in;
    logic             rail_i, rail_i_nx;
    logic             rail_q, rail_q_nx;
    logic             stb, stb_nx;
    logic             sym, sym_nx;
    logic             load;

    assign tc_in   = (i_nb_P < TC_MIN) ? TC_MIN : i_nb_P;
    assign idx_inc = idx + IDX_W'(1);

    always_comb begin
        // NOTE: every signal gets its hold/idle value first so no path through this block can infer a latch.
        state_nx  = state;
        shadow_nx = shadow;
        full_nx   = full;
        active_nx = active;
        cnt_nx    = cnt;
        idx_nx    = idx;
        tc_nx     = tc_lat;
        rail_i_nx = rail_i;
        rail_q_nx = rail_q;
        stb_nx    = 1'b0;
        sym_nx    = 1'b0;
        load      = 1'b0;

        case (state)
            IDLE: begin
                if (full) begin
                    load = 1'b1;
                end
            end
            RUN: begin
                if (cnt != tc_lat) begin
                    cnt_nx = cnt + CNT_ONE;
                end else if (idx != LAST_IDX) begin
                    idx_nx    = idx_inc;
                    cnt_nx    = CNT_ONE;
                    stb_nx    = 1'b1;
                    sym_nx    = (idx_inc == LAST_IDX);
                    active_nx = {1'b0, active[CHIPS-1:1]};
                    // The chip being issued has index idx+1: odd idx means an even chip, i.e. the I rail.
                    if (idx[0]) begin
                        rail_i_nx = active[0];
                    end else begin
                        rail_q_nx = active[0];
                    end
                end else if (full) begin
                    load = 1'b1;
                end else begin
                    state_nx  = IDLE;
                    rail_i_nx = 1'b0;
                    rail_q_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A load emits chip 0 immediately and keeps the remaining chips in the shift register.
        if (load) begin
            state_nx  = RUN;
            full_nx   = 1'b0;
            active_nx = {1'b0, shadow[CHIPS-1:1]};
            rail_i_nx = shadow[0];
            stb_nx    = 1'b1;
            cnt_nx    = CNT_ONE;
            idx_nx    = '0;
            tc_nx     = tc_in;
        end

        // Loads only happen with full=1 and handshakes only with full=0, so these never collide.
        if (i_valid && !full) begin
            shadow_nx = i_chips;
            full_nx   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
        if (i_rst) begin
            state  <= IDLE;
            full   <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
            tc_lat <= TC_MIN;
            rail_i <= 1'b0;
            rail_q <= 1'b0;
            stb    <= 1'b0;
            sym    <= 1'b0;
        end else begin
            state  <= state_nx;
            full   <= full_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            tc_lat <= tc_nx;
            rail_i <= rail_i_nx;
            rail_q <= rail_q_nx;
            stb    <= stb_nx;
            sym    <= sym_nx;
        end
    end

    // NOTE: the data registers carry no reset; full and state decide when their contents are meaningful.
    always_ff @(posedge i_clk) begin
        shadow <= shadow_nx;
        active <= active_nx;
    end

    assign o_ready    = ~full;
    assign o_busy     = (state == RUN);
    assign o_i        = rail_i;
    assign o_q        = rail_q;
    assign o_chip_stb = stb;
    assign o_sym_done = sym;

endmodule
